// File: rtl/simon_48_72.sv
`timescale 1ns/1ps
// simon_48_72 - iterative SIMON 48/72 block cipher core.
//
// One round per clock. Keys are expanded on chip into a T x N round-key store,
// one word per clock, after a key load. Blocks are loaded through a
// request/acknowledge handshake and the result is held on cipher_o until the
// next result is written.
//
// Build option: define SIMON_DECRYPT_EN to support decryption (enc_dec_i = 0).
// Without it enc_dec_i is ignored and every block is encrypted.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   new_key_i    key load request; key_i[0] is k0
//   ld_key_o     key captured (falls once new_key_i is seen low)
//   done_key_o   all T round keys available
//   new_data_i   block load request; plain_i = {x, y}, enc_dec_i 1 = encrypt
//   ld_data_o    block captured (falls once new_data_i is seen low)
//   done_data_o  result valid on cipher_o; cleared by read_data_i
//   cipher_o     result block {x, y}
module simon_48_72 #(
    parameter int unsigned N  = 24,
    parameter int unsigned M  = 3,
    parameter int unsigned T  = 36,
    parameter int unsigned Co = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                new_key_i,
    input  logic [M-1:0][N-1:0] key_i,
    output logic                ld_key_o,
    output logic                done_key_o,
    input  logic                new_data_i,
    input  logic [2*N-1:0]      plain_i,
    input  logic                enc_dec_i,
    output logic                ld_data_o,
    output logic                done_data_o,
    input  logic                read_data_i,
    output logic [2*N-1:0]      cipher_o
);
    localparam logic [N-1:0] KeyConst = {{(N-2){1'b1}}, 2'b00};
    // z0 sequence, MSB first: bit for schedule step i is Z0[61 - i].
    localparam logic [61:0]  Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic [1:0] {KeyIdle, KeyExpand, KeyReady} key_state_e;
    typedef enum logic [1:0] {DataIdle, DataRun, DataDone} data_state_e;

    function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned s);
        return rol(v, N - s);
    endfunction

    function automatic logic [N-1:0] rnd_f(input logic [N-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    // Key side
    key_state_e     key_state_q, key_state_d;
    logic [Co-1:0]  kcnt_q, kcnt_d;
    logic           ld_key_q, ld_key_d;
    logic           done_key_q, done_key_d;
    logic [N-1:0]   ks_q [T];
    logic           key_start, exp_we;
    logic [Co-1:0]  z_idx;
    logic [5:0]     z_pos;
    logic [N-1:0]   km1, exp_word;

    // Data side
    data_state_e    data_state_q, data_state_d;
    logic [Co-1:0]  rcnt_q, rcnt_d;
    logic [N-1:0]   x_q, x_d, y_q, y_d;
    logic           ld_data_q, ld_data_d;
    logic           done_data_q, done_data_d;
    logic [2*N-1:0] cipher_q, cipher_d;
    logic           data_start;
    logic [Co-1:0]  rk_idx;
    logic [N-1:0]   rnd_x;

`ifdef SIMON_DECRYPT_EN
    logic dec_q, dec_d;
`else
    logic unused_enc_dec;
    assign unused_enc_dec = enc_dec_i;
`endif

    // kcnt_q is the index being written; step i = kcnt_q - M (always < 62 here).
    assign z_idx    = kcnt_q - Co'(M);
    assign z_pos    = 6'd61 - 6'(z_idx);
    assign km1      = ks_q[kcnt_q - Co'(1)];
    assign exp_word = KeyConst ^ N'(Z0[z_pos]) ^ ks_q[z_idx] ^ ror(km1, 3) ^ ror(km1, 4);

    assign data_start = (data_state_q == DataIdle) && new_data_i && done_key_q;

    always_comb begin
        key_state_d = key_state_q;
        kcnt_d      = kcnt_q;
        ld_key_d    = ld_key_q;
        done_key_d  = done_key_q;
        key_start   = 1'b0;
        exp_we      = 1'b0;
        if (!new_key_i) ld_key_d = 1'b0;
        case (key_state_q)
            KeyIdle, KeyReady: begin
                // A block starting this edge reads k0, so the key load waits.
                if (new_key_i && (data_state_q != DataRun) && !data_start) begin
                    key_start   = 1'b1;
                    key_state_d = KeyExpand;
                    kcnt_d      = Co'(M);
                    ld_key_d    = 1'b1;
                    done_key_d  = 1'b0;
                end
            end
            KeyExpand: begin
                exp_we = 1'b1;
                kcnt_d = kcnt_q + Co'(1);
                if (kcnt_q == Co'(T - 1)) begin
                    key_state_d = KeyReady;
                    done_key_d  = 1'b1;
                end
            end
            default: key_state_d = KeyIdle;
        endcase
    end

`ifdef SIMON_DECRYPT_EN
    assign rk_idx = dec_q ? (Co'(T - 1) - rcnt_q) : rcnt_q;
`else
    assign rk_idx = rcnt_q;
`endif
    assign rnd_x = y_q ^ rnd_f(x_q) ^ ks_q[rk_idx];

    always_comb begin
        data_state_d = data_state_q;
        rcnt_d       = rcnt_q;
        x_d          = x_q;
        y_d          = y_q;
        ld_data_d    = ld_data_q;
        done_data_d  = done_data_q;
        cipher_d     = cipher_q;
`ifdef SIMON_DECRYPT_EN
        dec_d        = dec_q;
`endif
        if (!new_data_i) ld_data_d = 1'b0;
        case (data_state_q)
            DataIdle: begin
                if (data_start) begin
                    data_state_d = DataRun;
                    rcnt_d       = '0;
                    ld_data_d    = 1'b1;
                    x_d          = plain_i[2*N-1:N];
                    y_d          = plain_i[N-1:0];
`ifdef SIMON_DECRYPT_EN
                    dec_d = !enc_dec_i;
                    // Decryption runs the forward round on the swapped block.
                    if (!enc_dec_i) begin
                        x_d = plain_i[N-1:0];
                        y_d = plain_i[2*N-1:N];
                    end
`endif
                end
            end
            DataRun: begin
                x_d    = rnd_x;
                y_d    = x_q;
                rcnt_d = rcnt_q + Co'(1);
                if (rcnt_q == Co'(T - 1)) begin
                    data_state_d = DataDone;
                    done_data_d  = 1'b1;
                    cipher_d     = {rnd_x, x_q};
`ifdef SIMON_DECRYPT_EN
                    if (dec_q) cipher_d = {x_q, rnd_x};
`endif
                end
            end
            DataDone: begin
                if (read_data_i) begin
                    done_data_d  = 1'b0;
                    data_state_d = DataIdle;
                end
            end
            default: data_state_d = DataIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_state_q  <= KeyIdle;
            kcnt_q       <= '0;
            ld_key_q     <= 1'b0;
            done_key_q   <= 1'b0;
            data_state_q <= DataIdle;
            rcnt_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            ld_data_q    <= 1'b0;
            done_data_q  <= 1'b0;
            cipher_q     <= '0;
`ifdef SIMON_DECRYPT_EN
            dec_q        <= 1'b0;
`endif
        end else begin
            key_state_q  <= key_state_d;
            kcnt_q       <= kcnt_d;
            ld_key_q     <= ld_key_d;
            done_key_q   <= done_key_d;
            data_state_q <= data_state_d;
            rcnt_q       <= rcnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            ld_data_q    <= ld_data_d;
            done_data_q  <= done_data_d;
            cipher_q     <= cipher_d;
`ifdef SIMON_DECRYPT_EN
            dec_q        <= dec_d;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < T; i++) ks_q[i] <= '0;
        end else if (key_start) begin
            for (int i = 0; i < M; i++) ks_q[i] <= key_i[i];
        end else if (exp_we) begin
            ks_q[kcnt_q] <= exp_word;
        end
    end

    assign ld_key_o    = ld_key_q;
    assign done_key_o  = done_key_q;
    assign ld_data_o   = ld_data_q;
    assign done_data_o = done_data_q;
    assign cipher_o    = cipher_q;

endmodule

// File: tb/tb_simon_48_72.sv
`timescale 1ns/1ps
// tb_simon_48_72 - self-checking bench for simon_48_72 with a behavioural
// SIMON 48/72 reference model (key schedule, encrypt, inverse-round decrypt).
module tb_simon_48_72;
    localparam logic [71:0] KatKey = 72'h1211100A0908020100;
    localparam logic [47:0] KatPt  = 48'h6120676E696C;
    localparam logic [47:0] KatCt  = 48'hDAE5AC292CAC;
`ifdef SIMON_DECRYPT_EN
    localparam bit DecEn = 1'b1;
`else
    localparam bit DecEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_key = 1'b0;
    logic [71:0] key_w = '0;
    logic        ld_key, done_key;
    logic        new_data = 1'b0;
    logic [47:0] plain = '0;
    logic        enc_dec = 1'b1;
    logic        ld_data, done_data;
    logic        read_data = 1'b0;
    logic [47:0] cipher;

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] mk [36];
    string zs = "11111010001001010110000111001101111101000100101011000011100110";

    always #5 clk = ~clk;

    simon_48_72 dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .new_key_i   (new_key),
        .key_i       (key_w),
        .ld_key_o    (ld_key),
        .done_key_o  (done_key),
        .new_data_i  (new_data),
        .plain_i     (plain),
        .enc_dec_i   (enc_dec),
        .ld_data_o   (ld_data),
        .done_data_o (done_data),
        .read_data_i (read_data),
        .cipher_o    (cipher)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] rotl(input logic [23:0] v, input int s);
        return (v << s) | (v >> (24 - s));
    endfunction

    function automatic logic [23:0] rotr(input logic [23:0] v, input int s);
        return rotl(v, 24 - s);
    endfunction

    function automatic logic [23:0] fn(input logic [23:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    function automatic void model_expand(input logic [71:0] k);
        logic [23:0] tmp, zb;
        mk[0] = k[23:0];
        mk[1] = k[47:24];
        mk[2] = k[71:48];
        for (int i = 0; i < 33; i++) begin
            zb  = (zs.getc(i) == "1") ? 24'd1 : 24'd0;
            tmp = rotr(mk[i+2], 3);
            tmp = tmp ^ rotr(tmp, 1);
            mk[i+3] = 24'hFFFFFC ^ zb ^ mk[i] ^ tmp;
        end
    endfunction

    function automatic logic [47:0] model_enc(input logic [47:0] p);
        logic [23:0] x, y, t;
        x = p[47:24];
        y = p[23:0];
        for (int i = 0; i < 36; i++) begin
            t = x;
            x = y ^ fn(x) ^ mk[i];
            y = t;
        end
        return {x, y};
    endfunction

    // Undo rounds 35..0: x = y', y = x' ^ f(y') ^ k.
    function automatic logic [47:0] model_dec(input logic [47:0] c);
        logic [23:0] x, y, t;
        x = c[47:24];
        y = c[23:0];
        for (int i = 35; i >= 0; i--) begin
            t = y;
            y = x ^ fn(y) ^ mk[i];
            x = t;
        end
        return {x, y};
    endfunction

    function automatic logic [47:0] model_run(input logic [47:0] p, input bit enc);
        return (enc || !DecEn) ? model_enc(p) : model_dec(p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [71:0] k, input bit pend, input logic [47:0] p);
        int n;
        model_expand(k);
        key_w   = k;
        new_key = 1'b1;
        tick();
        check("ld_key_rise", 48'(ld_key), 48'd1);
        check("done_key_clr", 48'(done_key), 48'd0);
        new_key = 1'b0;
        if (pend) begin
            plain    = p;
            enc_dec  = 1'b1;
            new_data = 1'b1;
        end
        n = 0;
        while (!done_key && n < 100) begin
            tick();
            n++;
            if (n == 1) check("ld_key_fall", 48'(ld_key), 48'd0);
        end
        check("key_latency", 48'(n), 48'd33);
        check("k35", 48'(dut.ks_q[35]), 48'(mk[35]));
        if (pend) check("pend_no_cap", 48'(ld_data), 48'd0);
    endtask

    task automatic start_block(input logic [47:0] p, input bit enc, output int n);
        plain    = p;
        enc_dec  = enc;
        new_data = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ld_data && n < 200);
        new_data = 1'b0;
    endtask

    task automatic finish_block(input logic [47:0] exp, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) check("ld_data_fall", 48'(ld_data), 48'd0);
        end while (!done_data && n < 100);
        check("data_latency", 48'(n), 48'd36);
        check(tag, cipher, exp);
    endtask

    task automatic read_result();
        tick();
        check("done_hold", 48'(done_data), 48'd1);
        read_data = 1'b1;
        tick();
        check("done_clr", 48'(done_data), 48'd0);
        read_data = 1'b0;
    endtask

    initial begin
        int n;
        logic [71:0] kr;
        logic [47:0] p, p2, e;
        bit enc;

        // Reset
        #12;
        check("rst_out", {cipher[43:0], ld_key, done_key, ld_data, done_data}, 48'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_out", {cipher[43:0], ld_key, done_key, ld_data, done_data}, 48'd0);

        // Key load with a block request already pending
        load_key(KatKey, 1'b1, KatPt);
        start_block(KatPt, 1'b1, n);
        check("pend_cap_edge", 48'(n), 48'd1);
        finish_block(KatCt, "kat_enc");
        read_result();

        // Known-answer decrypt (encrypts when decryption is not built in)
        start_block(KatCt, 1'b0, n);
        check("cap_wait", 48'(n), 48'd1);
        finish_block(DecEn ? KatPt : model_enc(KatCt), "kat_dec");

        // Next request while read_data is still high
        p = 48'(({$urandom(), $urandom()}));
        e = model_run(p, 1'b1);
        plain     = p;
        enc_dec   = 1'b1;
        read_data = 1'b1;
        new_data  = 1'b1;
        tick();
        check("b2b_done_clr", 48'(done_data), 48'd0);
        check("b2b_no_cap", 48'(ld_data), 48'd0);
        tick();
        check("b2b_cap", 48'(ld_data), 48'd1);
        read_data = 1'b0;
        new_data  = 1'b0;
        finish_block(e, "b2b_cipher");
        read_result();

        // Random keys and blocks
        for (int kk = 0; kk < 3; kk++) begin
            kr = 72'({$urandom(), $urandom(), $urandom()});
            load_key(kr, 1'b0, '0);
            for (int b = 0; b < 3; b++) begin
                p   = 48'(({$urandom(), $urandom()}));
                enc = 1'($urandom_range(0, 1));
                e   = model_run(p, enc);
                start_block(p, enc, n);
                check("cap_wait", 48'(n), 48'd1);
                finish_block(e, "rand_cipher");
                read_result();
            end
        end

        // Key request during a run is deferred to the end of the run
        p  = 48'(({$urandom(), $urandom()}));
        e  = model_run(p, 1'b1);
        kr = 72'({$urandom(), $urandom(), $urandom()});
        start_block(p, 1'b1, n);
        key_w   = kr;
        new_key = 1'b1;
        finish_block(e, "defer_cipher");
        check("defer_ld_key_low", 48'(ld_key), 48'd0);
        tick();
        check("defer_ld_key_cap", 48'(ld_key), 48'd1);
        new_key = 1'b0;
        n = 0;
        while (!done_key && n < 100) begin
            tick();
            n++;
        end
        check("defer_key_latency", 48'(n), 48'd33);
        model_expand(kr);
        read_data = 1'b1;
        tick();
        read_data = 1'b0;
        p2 = 48'(({$urandom(), $urandom()}));
        start_block(p2, 1'b0, n);
        finish_block(model_run(p2, 1'b0), "defer_new_key");
        read_result();

        // Reset during round 20, then reload and rerun the known answer
        load_key(KatKey, 1'b0, '0);
        start_block(KatPt, 1'b1, n);
        repeat (20) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cipher", cipher, 48'd0);
        check("midrst_status", 48'({ld_key, done_key, ld_data, done_data}), 48'd0);
        #3 rst_n = 1'b1;
        repeat (40) tick();
        check("midrst_quiet", 48'({ld_key, done_key, ld_data, done_data}), 48'd0);
        load_key(KatKey, 1'b0, '0);
        start_block(KatPt, 1'b1, n);
        finish_block(KatCt, "kat_after_rst");
        read_result();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
